aes_req_sched: RTL and testbench

Request scheduler that shares one AES core (`aes_core_gen`) between `NUM_REQ` independent requesters. It arbitrates round-robin among pending requests and latches the winner's key, data, mode and direction. It then pulses the core's start, waits for done with a watchdog, and returns the result with the requester's ID over a valid/ready response channel. It sits directly in front of the core; the core's ports connect only to this block.

---
 rtl/aes_sched_pkg.sv | 20 ++
 rtl/aes_rr_arbiter.sv | 30 +++
 rtl/aes_req_sched.sv | 155 +++++++++++++++
 tb/tb_aes_req_sched.sv | 424 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/aes_sched_pkg.sv
// Shared types and constants for the AES request scheduler.
package aes_sched_pkg;

    localparam int MODE_W = 2;
    localparam int KEY_W  = 256;
    localparam int BLK_W  = 128;

    localparam logic [MODE_W-1:0] AES_MODE_128     = 2'b00;
    localparam logic [MODE_W-1:0] AES_MODE_192     = 2'b01;
    localparam logic [MODE_W-1:0] AES_MODE_256     = 2'b10;
    localparam logic [MODE_W-1:0] AES_MODE_ILLEGAL = 2'b11;

    typedef enum logic [1:0] {
        IDLE,
        START,
        BUSY,
        RESP
    } sched_state_t;

endpackage

// File: rtl/aes_rr_arbiter.sv
// Round-robin arbiter: first requester at or after ptr, wrapping.
module aes_rr_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int ID_W    = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [ID_W-1:0]    ptr,
    output logic [NUM_REQ-1:0] grant,
    output logic [ID_W-1:0]    grant_idx
);

    logic            found;
    logic [ID_W-1:0] sel;

    always_comb begin
        grant     = '0;
        grant_idx = '0;
        found     = 1'b0;
        sel       = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            sel = ID_W'((int'(ptr) + i) % NUM_REQ);
            if (!found && req[sel]) begin
                found      = 1'b1;
                grant[sel] = 1'b1;
                grant_idx  = sel;
            end
        end
    end

endmodule

// File: rtl/aes_req_sched.sv
// Shares one AES core among NUM_REQ requesters with round-robin
// arbitration, a done watchdog and a valid/ready response channel.
module aes_req_sched
    import aes_sched_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int ID_W    = $clog2(NUM_REQ),
    parameter int TIMEOUT = 64
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [NUM_REQ-1:0]      req_valid,
    output logic [NUM_REQ-1:0]      req_ready,
    input  logic [NUM_REQ-1:0]      req_enc_dec,
    input  logic [2*NUM_REQ-1:0]    req_mode,
    input  logic [256*NUM_REQ-1:0]  req_key,
    input  logic [128*NUM_REQ-1:0]  req_data,
    output logic                    rsp_valid,
    input  logic                    rsp_ready,
    output logic [ID_W-1:0]         rsp_id,
    output logic [127:0]            rsp_data,
    output logic                    rsp_err,
    output logic                    core_start,
    output logic                    core_enc_dec,
    output logic [1:0]              core_mode,
    output logic [255:0]            core_key,
    output logic [127:0]            core_data_in,
    input  logic [127:0]            core_data_out,
    input  logic                    core_done
);

    localparam int              WD_W    = $clog2(TIMEOUT);
    localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT - 1);
    localparam logic [ID_W-1:0] LAST_ID = ID_W'(NUM_REQ - 1);

    sched_state_t       state, state_nxt;
    logic [NUM_REQ-1:0] grant;
    logic [ID_W-1:0]    grant_idx, g, rr_ptr;
    logic [WD_W-1:0]    wdog;
    logic               sel_enc_dec;
    logic [MODE_W-1:0]  sel_mode;
    logic [KEY_W-1:0]   sel_key;
    logic [BLK_W-1:0]   sel_data;
    logic               any_req, illegal, wd_expired;

    aes_rr_arbiter #(
        .NUM_REQ (NUM_REQ),
        .ID_W    (ID_W)
    ) u_arb (
        .req       (req_valid),
        .ptr       (rr_ptr),
        .grant     (grant),
        .grant_idx (grant_idx)
    );

    assign any_req    = |req_valid;
    assign illegal    = (sel_mode == AES_MODE_ILLEGAL);
    assign wd_expired = (wdog == WD_LAST);
    // Gated by reset so the accept strobe is quiet while held in reset.
    assign req_ready  = (state == IDLE && !reset) ? grant : '0;

    always_comb begin
        sel_enc_dec = 1'b0;
        sel_mode    = '0;
        sel_key     = '0;
        sel_data    = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (grant[i]) begin
                sel_enc_dec = req_enc_dec[i];
                sel_mode    = req_mode[i*MODE_W +: MODE_W];
                sel_key     = req_key[i*KEY_W +: KEY_W];
                sel_data    = req_data[i*BLK_W +: BLK_W];
            end
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:  if (any_req) state_nxt = illegal ? RESP : START;
            START: state_nxt = BUSY;
            BUSY:  if (core_done || wd_expired) state_nxt = RESP;
            RESP:  if (rsp_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            g            <= '0;
            rr_ptr       <= '0;
            wdog         <= '0;
            rsp_valid    <= 1'b0;
            rsp_id       <= '0;
            rsp_data     <= '0;
            rsp_err      <= 1'b0;
            core_start   <= 1'b0;
            core_enc_dec <= 1'b0;
            core_mode    <= '0;
            core_key     <= '0;
            core_data_in <= '0;
        end else begin
            core_start <= 1'b0;
            case (state)
                IDLE: begin
                    if (any_req) begin
                        g            <= grant_idx;
                        core_enc_dec <= sel_enc_dec;
                        core_mode    <= sel_mode;
                        core_key     <= sel_key;
                        core_data_in <= sel_data;
                        if (illegal) begin
                            rsp_valid <= 1'b1;
                            rsp_err   <= 1'b1;
                            rsp_data  <= '0;
                            rsp_id    <= grant_idx;
                        end else begin
                            core_start <= 1'b1;
                        end
                    end
                end
                START: wdog <= '0;
                BUSY: begin
                    // A done arriving in the expiry cycle still counts.
                    if (core_done) begin
                        rsp_valid <= 1'b1;
                        rsp_err   <= 1'b0;
                        rsp_data  <= core_data_out;
                        rsp_id    <= g;
                    end else if (wd_expired) begin
                        rsp_valid <= 1'b1;
                        rsp_err   <= 1'b1;
                        rsp_data  <= '0;
                        rsp_id    <= g;
                    end else begin
                        wdog <= wdog + 1'b1;
                    end
                end
                RESP: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        rr_ptr    <= (g == LAST_ID) ? '0 : g + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_aes_req_sched.sv
// Directed self-checking bench for aes_req_sched with a stub core.
module tb_aes_req_sched;

    localparam int N   = 4;
    localparam int IDW = 2;
    localparam int TO  = 64;

    logic              clk = 1'b0;
    logic              reset;
    logic [N-1:0]      req_valid, req_ready, req_enc_dec;
    logic [2*N-1:0]    req_mode;
    logic [256*N-1:0]  req_key;
    logic [128*N-1:0]  req_data;
    logic              rsp_valid, rsp_ready, rsp_err;
    logic [IDW-1:0]    rsp_id;
    logic [127:0]      rsp_data;
    logic              core_start, core_enc_dec, core_done;
    logic [1:0]        core_mode;
    logic [255:0]      core_key;
    logic [127:0]      core_data_in, core_data_out;

    int n_checks = 0;
    int n_fail   = 0;

    localparam logic [127:0] FIPS_K = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] FIPS_D = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] FIPS_E = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;

    aes_req_sched #(.NUM_REQ(N), .ID_W(IDW), .TIMEOUT(TO)) dut (
        .clk           (clk),
        .reset         (reset),
        .req_valid     (req_valid),
        .req_ready     (req_ready),
        .req_enc_dec   (req_enc_dec),
        .req_mode      (req_mode),
        .req_key       (req_key),
        .req_data      (req_data),
        .rsp_valid     (rsp_valid),
        .rsp_ready     (rsp_ready),
        .rsp_id        (rsp_id),
        .rsp_data      (rsp_data),
        .rsp_err       (rsp_err),
        .core_start    (core_start),
        .core_enc_dec  (core_enc_dec),
        .core_mode     (core_mode),
        .core_key      (core_key),
        .core_data_in  (core_data_in),
        .core_data_out (core_data_out),
        .core_done     (core_done)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic idle_inputs();
        req_valid     = '0;
        req_enc_dec   = '0;
        req_mode      = '0;
        req_key       = '0;
        req_data      = '0;
        rsp_ready     = 1'b1;
        core_data_out = '0;
        core_done     = 1'b0;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
        tick();
    endtask

    task automatic test_reset();
        idle_inputs();
        reset = 1'b1;
        req_valid = 4'hf;
        tick();
        n_checks++;
        if (req_ready !== 4'b0000) begin
            n_fail++;
            $display("FAIL reset_req_ready got %b want 0000", req_ready);
        end
        n_checks++;
        if ({rsp_valid, rsp_err, core_start, core_enc_dec, core_mode} !== 6'b0) begin
            n_fail++;
            $display("FAIL reset_ctrl got %b want 000000",
                     {rsp_valid, rsp_err, core_start, core_enc_dec, core_mode});
        end
        n_checks++;
        if (rsp_id !== 2'd0 || rsp_data !== 128'h0 || core_key !== 256'h0 ||
            core_data_in !== 128'h0) begin
            n_fail++;
            $display("FAIL reset_data got id=%0d d=%h k=%h di=%h want zeros",
                     rsp_id, rsp_data, core_key, core_data_in);
        end
        req_valid = '0;
        reset = 1'b0;
        tick();
    endtask

    task automatic test_fips();
        bit ok;
        do_reset();
        req_valid      = 4'b0001;
        req_key[127:0] = FIPS_K;
        req_data[127:0] = FIPS_D;
        #1;
        n_checks++;
        if (req_ready !== 4'b0001) begin
            n_fail++;
            $display("FAIL fips_accept got %b want 0001", req_ready);
        end
        tick();
        req_valid = '0;
        n_checks++;
        if (core_start !== 1'b1 || core_key !== {128'h0, FIPS_K} ||
            core_data_in !== FIPS_D || core_mode !== 2'b00 || core_enc_dec !== 1'b0) begin
            n_fail++;
            $display("FAIL fips_start got st=%b k=%h d=%h want st=1 k=%h d=%h",
                     core_start, core_key, core_data_in, {128'h0, FIPS_K}, FIPS_D);
        end
        ok = 1'b1;
        for (int c = 2; c <= 12; c++) begin
            tick();
            if (core_start !== 1'b0 || rsp_valid !== 1'b0) ok = 1'b0;
        end
        n_checks++;
        if (!ok) begin
            n_fail++;
            $display("FAIL fips_wait got early start/valid want none in cycles 2..12");
        end
        core_done     = 1'b1;
        core_data_out = FIPS_E;
        tick();
        core_done = 1'b0;
        n_checks++;
        if (rsp_valid !== 1'b1 || rsp_data !== FIPS_E || rsp_id !== 2'd0 || rsp_err !== 1'b0) begin
            n_fail++;
            $display("FAIL fips_rsp got v=%b d=%h id=%0d e=%b want v=1 d=%h id=0 e=0",
                     rsp_valid, rsp_data, rsp_id, rsp_err, FIPS_E);
        end
        tick();
        n_checks++;
        if (rsp_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL fips_drop got v=%b want 0", rsp_valid);
        end
    endtask

    task automatic test_round_robin();
        int e;
        logic [127:0] exp_d;
        do_reset();
        for (int i = 0; i < N; i++) req_data[i*128 +: 128] = {4{32'ha0a00000 + 32'(i)}};
        req_valid = 4'hf;
        for (int k = 0; k < 5; k++) begin
            e = k % N;
            exp_d = ~{4{32'ha0a00000 + 32'(e)}};
            #1;
            n_checks++;
            if (req_ready !== 4'(1 << e)) begin
                n_fail++;
                $display("FAIL rr_grant%0d got %b want %b", k, req_ready, 4'(1 << e));
            end
            tick();
            n_checks++;
            if (core_start !== 1'b1) begin
                n_fail++;
                $display("FAIL rr_start%0d got %b want 1", k, core_start);
            end
            tick();
            n_checks++;
            if (core_start !== 1'b0) begin
                n_fail++;
                $display("FAIL rr_pulse%0d got %b want 0", k, core_start);
            end
            core_done     = 1'b1;
            core_data_out = ~core_data_in;
            tick();
            core_done = 1'b0;
            n_checks++;
            if (rsp_valid !== 1'b1 || rsp_id !== IDW'(e) || rsp_data !== exp_d || core_start !== 1'b0) begin
                n_fail++;
                $display("FAIL rr_rsp%0d got v=%b id=%0d d=%h want v=1 id=%0d d=%h",
                         k, rsp_valid, rsp_id, rsp_data, e, exp_d);
            end
            tick();
        end
    endtask

    task automatic test_illegal();
        idle_inputs();
        req_valid     = 4'b0100;
        req_mode[5:4] = 2'b11;
        #1;
        n_checks++;
        if (req_ready !== 4'b0100) begin
            n_fail++;
            $display("FAIL ill_accept got %b want 0100", req_ready);
        end
        tick();
        req_valid = '0;
        n_checks++;
        if (rsp_valid !== 1'b1 || rsp_err !== 1'b1 || rsp_data !== 128'h0 ||
            rsp_id !== 2'd2 || core_start !== 1'b0) begin
            n_fail++;
            $display("FAIL ill_rsp got v=%b e=%b d=%h id=%0d st=%b want 1 1 0 2 0",
                     rsp_valid, rsp_err, rsp_data, rsp_id, core_start);
        end
        tick();
        req_mode  = '0;
        req_valid = 4'hf;
        #1;
        n_checks++;
        if (rsp_valid !== 1'b0 || core_start !== 1'b0 || req_ready !== 4'b1000) begin
            n_fail++;
            $display("FAIL ill_ptr got v=%b st=%b rdy=%b want 0 0 1000",
                     rsp_valid, core_start, req_ready);
        end
        req_valid = '0;
        tick();
    endtask

    task automatic test_timeout();
        bit ok;
        do_reset();
        req_valid     = 4'b0001;
        req_mode[1:0] = 2'b01;
        tick();
        req_valid = '0;
        n_checks++;
        if (core_start !== 1'b1 || core_mode !== 2'b01) begin
            n_fail++;
            $display("FAIL to_start got st=%b m=%b want 1 01", core_start, core_mode);
        end
        ok = 1'b1;
        for (int c = 2; c <= 65; c++) begin
            tick();
            if (rsp_valid !== 1'b0) ok = 1'b0;
        end
        n_checks++;
        if (!ok) begin
            n_fail++;
            $display("FAIL to_early got early rsp_valid want none before cycle 66");
        end
        tick();
        n_checks++;
        if (rsp_valid !== 1'b1 || rsp_err !== 1'b1 || rsp_data !== 128'h0 || rsp_id !== 2'd0) begin
            n_fail++;
            $display("FAIL to_rsp got v=%b e=%b d=%h id=%0d want 1 1 0 0",
                     rsp_valid, rsp_err, rsp_data, rsp_id);
        end
        tick();
        core_done     = 1'b1;
        core_data_out = '1;
        ok = 1'b1;
        for (int c = 0; c < 3; c++) begin
            tick();
            core_done = 1'b0;
            if (rsp_valid !== 1'b0 || core_start !== 1'b0) ok = 1'b0;
        end
        n_checks++;
        if (!ok) begin
            n_fail++;
            $display("FAIL to_late got v=%b st=%b want 0 0", rsp_valid, core_start);
        end
    endtask

    task automatic test_done_edges();
        bit ok;
        idle_inputs();
        req_valid = 4'b0010;
        req_data[255:128] = 128'hcafef00d_00000000_11111111_deadbeef;
        #1;
        n_checks++;
        if (req_ready !== 4'b0010) begin
            n_fail++;
            $display("FAIL edge_accept got %b want 0010", req_ready);
        end
        tick();
        req_valid     = '0;
        core_done     = 1'b1;
        core_data_out = 128'h1;
        ok = 1'b1;
        for (int c = 2; c <= 65; c++) begin
            tick();
            core_done = 1'b0;
            if (rsp_valid !== 1'b0) ok = 1'b0;
        end
        n_checks++;
        if (!ok) begin
            n_fail++;
            $display("FAIL edge_start_done got early rsp_valid want none");
        end
        core_done     = 1'b1;
        core_data_out = 128'h0123456789abcdef_fedcba9876543210;
        tick();
        core_done = 1'b0;
        n_checks++;
        if (rsp_valid !== 1'b1 || rsp_err !== 1'b0 || rsp_id !== 2'd1 ||
            rsp_data !== 128'h0123456789abcdef_fedcba9876543210) begin
            n_fail++;
            $display("FAIL edge_last got v=%b e=%b id=%0d d=%h want 1 0 1 0123..3210",
                     rsp_valid, rsp_err, rsp_id, rsp_data);
        end
        tick();
    endtask

    task automatic test_stall();
        logic [127:0] s;
        s = 128'h5a5a5a5a_a5a5a5a5_0f0f0f0f_f0f0f0f0;
        idle_inputs();
        rsp_ready = 1'b0;
        req_valid = 4'hf;
        #1;
        n_checks++;
        if (req_ready !== 4'b0100) begin
            n_fail++;
            $display("FAIL stall_accept got %b want 0100", req_ready);
        end
        tick();
        tick();
        core_done     = 1'b1;
        core_data_out = s;
        tick();
        core_done = 1'b0;
        for (int c = 0; c < 10; c++) begin
            core_done     = (c == 4);
            core_data_out = ~s;
            #1;
            n_checks++;
            if (req_ready !== 4'b0000 || rsp_valid !== 1'b1 || rsp_data !== s ||
                rsp_id !== 2'd2 || rsp_err !== 1'b0) begin
                n_fail++;
                $display("FAIL stall_hold%0d got rdy=%b v=%b d=%h id=%0d e=%b", c,
                         req_ready, rsp_valid, rsp_data, rsp_id, rsp_err);
            end
            tick();
        end
        core_done = 1'b0;
        rsp_ready = 1'b1;
        tick();
        #1;
        n_checks++;
        if (rsp_valid !== 1'b0 || req_ready !== 4'b1000) begin
            n_fail++;
            $display("FAIL stall_release got v=%b rdy=%b want 0 1000", rsp_valid, req_ready);
        end
        req_valid = '0;
        tick();
    endtask

    task automatic test_reset_busy();
        bit ok;
        idle_inputs();
        req_valid = 4'b1000;
        req_enc_dec[3] = 1'b1;
        req_mode[7:6] = 2'b10;
        req_key[1023:768] = {8{32'h13572468}};
        req_data[511:384] = 128'hffff0000ffff0000ffff0000ffff0000;
        tick();
        req_valid = '0;
        tick();
        tick();
        reset = 1'b1;
        req_valid = 4'hf;
        #1;
        n_checks++;
        if ({rsp_valid, rsp_err, core_start, core_enc_dec, core_mode} !== 6'b0 ||
            req_ready !== 4'b0000 || rsp_id !== 2'd0 || rsp_data !== 128'h0) begin
            n_fail++;
            $display("FAIL rstbusy_ctrl got v=%b e=%b st=%b ed=%b m=%b rdy=%b id=%0d",
                     rsp_valid, rsp_err, core_start, core_enc_dec, core_mode, req_ready, rsp_id);
        end
        n_checks++;
        if (core_key !== 256'h0 || core_data_in !== 128'h0) begin
            n_fail++;
            $display("FAIL rstbusy_ops got k=%h d=%h want 0", core_key, core_data_in);
        end
        req_valid = '0;
        tick();
        reset = 1'b0;
        core_done     = 1'b1;
        core_data_out = 128'hbad;
        ok = 1'b1;
        for (int c = 0; c < 6; c++) begin
            tick();
            core_done = 1'b0;
            if (rsp_valid !== 1'b0 || core_start !== 1'b0) ok = 1'b0;
        end
        n_checks++;
        if (!ok) begin
            n_fail++;
            $display("FAIL rstbusy_norsp got response or start after reset want none");
        end
        req_valid = 4'hf;
        #1;
        n_checks++;
        if (req_ready !== 4'b0001) begin
            n_fail++;
            $display("FAIL rstbusy_ptr got %b want 0001", req_ready);
        end
        req_valid = '0;
        tick();
    endtask

    initial begin
        test_reset();
        test_fips();
        test_round_robin();
        test_illegal();
        test_timeout();
        test_done_edges();
        test_stall();
        test_reset_busy();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
